// File: rtl/round_pkg.sv
// Shared rounding-mode type and the round-up decision used by round_core.
package round_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'b00,
        RND_HALF_UP   = 2'b01,
        RND_HALF_EVEN = 2'b10,
        RND_RSVD      = 2'b11
    } round_mode_t;

    // r: first dropped bit, s: OR of the remaining dropped bits, l: lsb kept.
    function automatic logic rnd_inc(input round_mode_t mode, input logic r,
                                     input logic s, input logic l);
        logic inc;
        case (mode)
            RND_TRUNC:     inc = 1'b0;
            RND_HALF_EVEN: inc = r & (s | l);
            default:       inc = r;   // RND_RSVD behaves as half-up
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/round_core.sv
// Combinational round of an unsigned fixed-point magnitude to an integer, with carry-out.
module round_core
    import round_pkg::*;
#(
    parameter int IN_W   = 17,
    parameter int FRAC_W = 4
) (
    input  logic [IN_W-1:0]        data,
    input  round_mode_t            mode,
    output logic [IN_W-FRAC_W-1:0] res,
    output logic                   ovf
);

    localparam int OUT_W = IN_W - FRAC_W;

    logic             inc;
    logic [OUT_W:0]   sum;

    assign inc = rnd_inc(mode, data[FRAC_W-1], |data[FRAC_W-2:0], data[FRAC_W]);
    // One extra bit so that rounding 0x..FFF upward shows up as a carry.
    assign sum = {1'b0, data[IN_W-1:FRAC_W]} + {{OUT_W{1'b0}}, inc};
    assign res = sum[OUT_W-1:0];
    assign ovf = sum[OUT_W];

endmodule

// File: rtl/round_sat_pipe.sv
// Two-stage round/saturate pipeline with valid/ready on both sides.
// ROUND_SAT_PIPE_SAT_EN: clamp on overflow and count clamped outputs; otherwise wrap.
module round_sat_pipe
    import round_pkg::*;
#(
    parameter int IN_W   = 17,
    parameter int FRAC_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IN_W-FRAC_W-1:0] out_data,
    output logic                   out_sat,
    output logic [CNT_W-1:0]       sat_count
);

    localparam int OUT_W = IN_W - FRAC_W;

    function automatic logic [OUT_W-1:0] sat_fn(input logic [OUT_W-1:0] res, input logic ovf);
`ifdef ROUND_SAT_PIPE_SAT_EN
        return ovf ? {OUT_W{1'b1}} : res;
`else
        return res;
`endif
    endfunction

    logic              vld_p1, vld_p2;
    logic [IN_W-1:0]   data_p1;
    round_mode_t       mode_p1;
    logic [OUT_W-1:0]  res_p1;
    logic              ovf_p1;
    logic              adv_p1, adv_p2;

    assign adv_p2    = !vld_p2 || out_ready;
    assign adv_p1    = !vld_p1 || adv_p2;
    assign in_ready  = adv_p1;
    assign out_valid = vld_p2;

    // S1: capture sample and its mode
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            data_p1 <= in_data;
            mode_p1 <= round_mode_t'(in_mode);
        end
    end

    round_core #(.IN_W(IN_W), .FRAC_W(FRAC_W)) u_core (
        .data (data_p1),
        .mode (mode_p1),
        .res  (res_p1),
        .ovf  (ovf_p1)
    );

    // S2: output register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            out_data <= '0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_data <= sat_fn(res_p1, ovf_p1);
            end
        end
    end

`ifdef ROUND_SAT_PIPE_SAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sat <= 1'b0;
        end else if (adv_p2 && vld_p1) begin
            out_sat <= ovf_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (vld_p2 && out_ready && out_sat && (sat_count != {CNT_W{1'b1}})) begin
            sat_count <= sat_count + 1'b1;
        end
    end
`else
    assign out_sat   = 1'b0;
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_round_sat_pipe.sv
// Randomised and directed bench for round_sat_pipe against an arithmetic reference model.
module tb_round_sat_pipe;

    localparam int IN_W   = 17;
    localparam int FRAC_W = 4;
    localparam int CNT_W  = 8;
    localparam int OUT_W  = IN_W - FRAC_W;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             s;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;
    logic [CNT_W-1:0]  sat_count;

    int     n_cmp = 0;
    int     n_err = 0;
    exp_t   expq[$];
    int     exp_cnt = 0;
    logic   last_in_fire;
    logic   saw_ready_low;

    always #5 clk = ~clk;

    round_sat_pipe #(.IN_W(IN_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_count (sat_count)
    );

    // Reference: integer quotient plus remainder comparison against one half.
    function automatic exp_t model(input logic [IN_W-1:0] d, input logic [1:0] m);
        exp_t e;
        longint q, rem, half, r, maxv;
        q    = longint'(d) / (longint'(1) << FRAC_W);
        rem  = longint'(d) % (longint'(1) << FRAC_W);
        half = longint'(1) << (FRAC_W - 1);
        maxv = (longint'(1) << OUT_W) - 1;
        case (m)
            2'd0:    r = q;
            2'd2:    r = (rem > half || (rem == half && (q % 2) == 1)) ? q + 1 : q;
            default: r = (rem >= half) ? q + 1 : q;
        endcase
`ifdef ROUND_SAT_PIPE_SAT_EN
        if (r > maxv) begin
            e.d = OUT_W'(maxv);
            e.s = 1'b1;
        end else begin
            e.d = OUT_W'(r);
            e.s = 1'b0;
        end
`else
        e.d = OUT_W'(r % (maxv + 1));
        e.s = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic [1:0] m,
                         input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = ordy;
    endtask

    // One clock: check/retire outputs and record accepted inputs before the edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_in_fire = 1'b0;
        if (!rst) begin
            if (!in_ready) saw_ready_low = 1'b1;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = expq[0];
                    chk("out_data", out_data, e.d);
                    chk("out_sat", out_sat, e.s);
                    if (out_ready) begin
                        void'(expq.pop_front());
`ifdef ROUND_SAT_PIPE_SAT_EN
                        if (e.s && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
                    end
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(in_data, in_mode));
                last_in_fire = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            expq.delete();
            exp_cnt = 0;
        end
        chk("sat_count", sat_count, exp_cnt);
    endtask

    task automatic send1(input logic [IN_W-1:0] d, input logic [1:0] m);
        drive(1'b1, d, m, 1'b1);
        tick();
        drive(1'b0, '0, 2'd0, 1'b1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        drive(1'b0, '0, 2'd0, 1'b1);
        while ((expq.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", expq.size(), 0);
    endtask

    initial begin
        int idx;
        logic [IN_W-1:0] sdata [8];
        logic [1:0]      smode [8];

        saw_ready_low = 1'b0;
        rst = 1'b1;
        drive(1'b0, '0, 2'd0, 1'b1);
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);

        // Known-answer samples around the half boundary and the overflow corner.
        send1(17'h00018, 2'b01);
        send1(17'h00028, 2'b10);
        send1(17'h00028, 2'b01);
        send1(17'h0001F, 2'b00);
        send1(17'h00029, 2'b10);
        send1(17'h00038, 2'b10);
        send1(17'h00038, 2'b11);
        send1(17'h1FFF8, 2'b01);
        send1(17'h1FFF8, 2'b00);
        send1(17'h1FFF8, 2'b10);
        drain(20);

        // Back-to-back burst with the consumer stalled for three cycles.
        for (int i = 0; i < 8; i++) begin
            sdata[i] = IN_W'($urandom);
            smode[i] = 2'($urandom);
        end
        idx = 0;
        saw_ready_low = 1'b0;
        for (int cyc = 0; cyc < 40 && (idx < 8 || expq.size() != 0); cyc++) begin
            drive(idx < 8, (idx < 8) ? sdata[idx] : '0, (idx < 8) ? smode[idx] : 2'd0,
                  !(cyc >= 3 && cyc <= 5));
            tick();
            if (last_in_fire) idx++;
        end
        chk("burst_all_sent", idx, 8);
        chk("burst_in_ready_dropped", saw_ready_low, 1);
        drain(20);

        // Random traffic, biased toward the top of the range for overflow.
        for (int i = 0; i < 400; i++) begin
            logic [IN_W-1:0] d;
            d = IN_W'($urandom);
            if ($urandom_range(0, 3) == 0) d = {{(IN_W-FRAC_W){1'b1}}, FRAC_W'($urandom)};
            drive($urandom_range(0, 3) != 0, d, 2'($urandom), $urandom_range(0, 3) != 0);
            tick();
        end
        drain(40);

        // Reset with two samples in flight: both must vanish.
        send1(17'h1FFF8, 2'b01);
        drive(1'b1, 17'h00028, 2'b01, 1'b0);
        tick();
        drive(1'b0, '0, 2'd0, 1'b0);
        rst = 1'b1;
        tick();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sat_count", sat_count, 0);
        rst = 1'b0;
        drive(1'b0, '0, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_idle", out_valid, 0);
        end
        chk("post_rst_in_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
